// File: rtl/scr1_tapc_oversampling_sync.sv
// Oversampling JTAG-to-clk synchronizer: deglitches raw TCK in the clk domain and issues
// aligned single-cycle chain strobes toward the core, returning TDO toward the TAPC.
module scr1_tapc_oversampling_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_PHASE    = 2,
  parameter int CH_NUM       = 2,
  parameter int CH_ID_WIDTH  = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int GLITCH_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tapc_tck_i,
  input  logic                    tapc_trst_n_i,
  input  logic [CH_NUM-1:0]       tapc_ch_sel_i,
  input  logic [CH_ID_WIDTH-1:0]  tapc_ch_id_i,
  input  logic                    tapc_ch_capture_i,
  input  logic                    tapc_ch_shift_i,
  input  logic                    tapc_ch_update_i,
  input  logic                    tapc_ch_tdi_i,
  output logic                    tapc_ch_tdo_o,
  output logic                    core_ch_rise_o,
  output logic                    core_ch_capture_o,
  output logic                    core_ch_shift_o,
  output logic                    core_ch_tdi_o,
  output logic                    core_ch_update_o,
  output logic [CH_NUM-1:0]       core_ch_sel_o,
  output logic [CH_ID_WIDTH-1:0]  core_ch_id_o,
  input  logic                    core_ch_tdo_i,
  output logic                    tck_active_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  localparam int DLY_LEN = SYNC_STAGES + MIN_PHASE - 1;
  localparam int DAT_W   = CH_NUM + CH_ID_WIDTH + 4;
  localparam int PH_W    = (MIN_PHASE > 1) ? $clog2(MIN_PHASE) : 1;
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0]  tck_sync_q;
  logic [SYNC_STAGES-1:0]  trst_sync_q;
  logic                    tck_s;
  logic                    trst_s;
  logic [DAT_W-1:0]        dat_raw_s;
  logic [DAT_W-1:0]        dly_q [DLY_LEN];
  logic [DAT_W-1:0]        dly_out_s;

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         cnt_q, cnt_d;
  logic                    rise_s, fall_s, glitch_s;

  logic                    rise_q, rise_d;
  logic                    cap_q, cap_d;
  logic                    shift_q, shift_d;
  logic                    tdi_q, tdi_d;
  logic                    upd_q, upd_d;
  logic [CH_NUM-1:0]       sel_q, sel_d;
  logic [CH_ID_WIDTH-1:0]  id_q, id_d;
  logic                    tdo_q, tdo_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic                    active_q, active_d;
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  assign tck_s     = tck_sync_q[SYNC_STAGES-1];
  assign trst_s    = trst_sync_q[SYNC_STAGES-1];
  assign dat_raw_s = {tapc_ch_sel_i, tapc_ch_id_i, tapc_ch_capture_i,
                      tapc_ch_shift_i, tapc_ch_tdi_i, tapc_ch_update_i};
  assign dly_out_s = dly_q[DLY_LEN-1];

  // Synchronizers and the data delay line; the line matches the TCK path so each strobe
  // carries the chain values seen at the clk edge that first sampled the new TCK level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync_q  <= {SYNC_STAGES{1'b0}};
      trst_sync_q <= {SYNC_STAGES{1'b0}};
      for (int i = 0; i < DLY_LEN; i++) begin
        dly_q[i] <= {DAT_W{1'b0}};
      end
    end else begin
      tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], tapc_tck_i};
      trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], tapc_trst_n_i};
      dly_q[0]    <= dat_raw_s;
      for (int i = 1; i < DLY_LEN; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Edge FSM: a new TCK level commits only after MIN_PHASE stable cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    glitch_s = 1'b0;
    if (!trst_s) begin
      state_d = ST_LOW;
      cnt_d   = {PH_W{1'b0}};
    end else begin
      case (state_q)
        ST_LOW: begin
          if (tck_s && (MIN_PHASE == 1)) begin
            state_d = ST_HIGH;
            rise_s  = 1'b1;
          end else if (tck_s) begin
            state_d = ST_RISE_PEND;
            cnt_d   = PH_W'(1);
          end else begin
            state_d = ST_LOW;
          end
        end
        ST_RISE_PEND: begin
          if (!tck_s) begin
            state_d  = ST_LOW;
            cnt_d    = {PH_W{1'b0}};
            glitch_s = 1'b1;
          end else if (cnt_q == PH_W'(MIN_PHASE - 1)) begin
            state_d = ST_HIGH;
            cnt_d   = {PH_W{1'b0}};
            rise_s  = 1'b1;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        ST_HIGH: begin
          if (!tck_s && (MIN_PHASE == 1)) begin
            state_d = ST_LOW;
            fall_s  = 1'b1;
          end else if (!tck_s) begin
            state_d = ST_FALL_PEND;
            cnt_d   = PH_W'(1);
          end else begin
            state_d = ST_HIGH;
          end
        end
        ST_FALL_PEND: begin
          if (tck_s) begin
            state_d  = ST_HIGH;
            cnt_d    = {PH_W{1'b0}};
            glitch_s = 1'b1;
          end else if (cnt_q == PH_W'(MIN_PHASE - 1)) begin
            state_d = ST_LOW;
            cnt_d   = {PH_W{1'b0}};
            fall_s  = 1'b1;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = {PH_W{1'b0}};
        end
      endcase
    end
  end

  // Output next-state: strobes, held chain context, TDO return, idle and glitch monitors.
  always_comb begin
    rise_d   = rise_s;
    cap_d    = rise_s & dly_out_s[3];
    shift_d  = rise_s & dly_out_s[2];
    tdi_d    = rise_s & dly_out_s[1];
    upd_d    = fall_s & dly_out_s[0];
    sel_d    = rise_s ? dly_out_s[DAT_W-1 -: CH_NUM] : sel_q;
    id_d     = rise_s ? dly_out_s[4 +: CH_ID_WIDTH] : id_q;
    tdo_d    = fall_s ? core_ch_tdo_i : tdo_q;
    idle_d   = idle_q;
    active_d = active_q;
    glitch_d = glitch_q;
    if (glitch_s && (glitch_q != {GLITCH_CNT_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_CNT_W'(1);
    end else begin
      glitch_d = glitch_q;
    end
    if (!trst_s) begin
      sel_d    = {CH_NUM{1'b0}};
      id_d     = {CH_ID_WIDTH{1'b0}};
      tdo_d    = 1'b0;
      idle_d   = {IDLE_W{1'b0}};
      active_d = 1'b0;
    end else if (rise_s || fall_s) begin
      idle_d   = {IDLE_W{1'b0}};
      active_d = 1'b1;
    end else if (idle_q == IDLE_W'(IDLE_TIMEOUT)) begin
      active_d = 1'b0;
    end else begin
      idle_d   = idle_q + IDLE_W'(1);
      active_d = (idle_d == IDLE_W'(IDLE_TIMEOUT)) ? 1'b0 : active_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      cnt_q    <= {PH_W{1'b0}};
      rise_q   <= 1'b0;
      cap_q    <= 1'b0;
      shift_q  <= 1'b0;
      tdi_q    <= 1'b0;
      upd_q    <= 1'b0;
      sel_q    <= {CH_NUM{1'b0}};
      id_q     <= {CH_ID_WIDTH{1'b0}};
      tdo_q    <= 1'b0;
      idle_q   <= {IDLE_W{1'b0}};
      active_q <= 1'b0;
      glitch_q <= {GLITCH_CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      cap_q    <= cap_d;
      shift_q  <= shift_d;
      tdi_q    <= tdi_d;
      upd_q    <= upd_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      tdo_q    <= tdo_d;
      idle_q   <= idle_d;
      active_q <= active_d;
      glitch_q <= glitch_d;
    end
  end

  assign tapc_ch_tdo_o     = tdo_q;
  assign core_ch_rise_o    = rise_q;
  assign core_ch_capture_o = cap_q;
  assign core_ch_shift_o   = shift_q;
  assign core_ch_tdi_o     = tdi_q;
  assign core_ch_update_o  = upd_q;
  assign core_ch_sel_o     = sel_q;
  assign core_ch_id_o      = id_q;
  assign tck_active_o      = active_q;
  assign glitch_cnt_o      = glitch_q;

endmodule

// File: tb/tb_scr1_tapc_oversampling_sync.sv
// Randomized scoreboard bench for scr1_tapc_oversampling_sync: a run-length model of the
// deglitched TCK predicts strobes into a queue that a monitor pops as the DUT emits them.
module tb_scr1_tapc_oversampling_sync;

  localparam int S = 2;
  localparam int M = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tapc_tck_i = 1'b0;
  logic       tapc_trst_n_i = 1'b0;
  logic [1:0] tapc_ch_sel_i = 2'b00;
  logic [1:0] tapc_ch_id_i = 2'b00;
  logic       tapc_ch_capture_i = 1'b0;
  logic       tapc_ch_shift_i = 1'b0;
  logic       tapc_ch_update_i = 1'b0;
  logic       tapc_ch_tdi_i = 1'b0;
  logic       core_ch_tdo_i = 1'b0;
  logic       tapc_ch_tdo_o;
  logic       core_ch_rise_o, core_ch_capture_o, core_ch_shift_o, core_ch_tdi_o;
  logic       core_ch_update_o;
  logic [1:0] core_ch_sel_o, core_ch_id_o;
  logic       tck_active_o;
  logic [7:0] glitch_cnt_o;

  scr1_tapc_oversampling_sync #(
    .SYNC_STAGES(S), .MIN_PHASE(M), .CH_NUM(2), .CH_ID_WIDTH(2),
    .IDLE_TIMEOUT(T), .GLITCH_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tapc_tck_i(tapc_tck_i), .tapc_trst_n_i(tapc_trst_n_i),
    .tapc_ch_sel_i(tapc_ch_sel_i), .tapc_ch_id_i(tapc_ch_id_i),
    .tapc_ch_capture_i(tapc_ch_capture_i), .tapc_ch_shift_i(tapc_ch_shift_i),
    .tapc_ch_update_i(tapc_ch_update_i), .tapc_ch_tdi_i(tapc_ch_tdi_i),
    .tapc_ch_tdo_o(tapc_ch_tdo_o),
    .core_ch_rise_o(core_ch_rise_o), .core_ch_capture_o(core_ch_capture_o),
    .core_ch_shift_o(core_ch_shift_o), .core_ch_tdi_o(core_ch_tdi_o),
    .core_ch_update_o(core_ch_update_o),
    .core_ch_sel_o(core_ch_sel_o), .core_ch_id_o(core_ch_id_o),
    .core_ch_tdo_i(core_ch_tdo_i),
    .tck_active_o(tck_active_o), .glitch_cnt_o(glitch_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         is_rise;
    logic [7:0] d;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // reference model state
  logic       h_tck [64];
  logic       h_trst [64];
  logic [7:0] h_dat [64];
  logic       lvl;
  int         run;
  int         m_glitch, m_idle;
  logic       m_active, m_tdo;
  logic [1:0] m_sel, m_id;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: committed level flips after M consecutive synchronized samples at the other level;
  // a shorter excursion counts as a glitch. Samples reach the edge detector S clocks late.
  initial begin
    for (int i = 0; i < 64; i++) begin
      h_tck[i] = 1'b0; h_trst[i] = 1'b0; h_dat[i] = 8'h00;
    end
    lvl = 1'b0; run = 0; m_glitch = 0; m_idle = 0;
    m_active = 1'b0; m_tdo = 1'b0; m_sel = 2'b00; m_id = 2'b00;
    forever begin
      logic       s, t, rise, fall;
      logic [7:0] d;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < 64; i++) begin
          h_tck[i] = 1'b0; h_trst[i] = 1'b0; h_dat[i] = 8'h00;
        end
        lvl = 1'b0; run = 0; m_glitch = 0; m_idle = 0;
        m_active = 1'b0; m_tdo = 1'b0; m_sel = 2'b00; m_id = 2'b00;
      end else begin
        h_tck[cyc % 64]  = tapc_tck_i;
        h_trst[cyc % 64] = tapc_trst_n_i;
        h_dat[cyc % 64]  = {tapc_ch_sel_i, tapc_ch_id_i, tapc_ch_capture_i,
                            tapc_ch_shift_i, tapc_ch_tdi_i, tapc_ch_update_i};
        s = h_tck[(cyc + 64 - S) % 64];
        t = h_trst[(cyc + 64 - S) % 64];
        d = h_dat[(cyc + 64 - S - M + 1) % 64];
        rise = 1'b0;
        fall = 1'b0;
        if (!t) begin
          lvl = 1'b0; run = 0; m_idle = 0; m_active = 1'b0;
          m_sel = 2'b00; m_id = 2'b00; m_tdo = 1'b0;
        end else begin
          if (s != lvl) begin
            run++;
            if (run == M) begin
              run = 0;
              lvl = s;
              rise = s;
              fall = !s;
            end
          end else begin
            if (run > 0 && m_glitch < 255) m_glitch++;
            run = 0;
          end
          if (rise) begin
            m_sel = d[7:6];
            m_id  = d[5:4];
            evq.push_back('{cyc, 1'b1, d});
          end
          if (fall) begin
            m_tdo = core_ch_tdo_i;
            if (d[0]) evq.push_back('{cyc, 1'b0, d});
          end
          if (rise || fall) begin
            m_idle = 0;
            m_active = 1'b1;
          end else if (m_idle < T) begin
            m_idle++;
            if (m_idle == T) m_active = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expected strobes as the DUT presents them, and compares held state each cycle.
  initial begin
    forever begin
      ev_t ev;
      @(posedge clk);
      #1;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        ev = evq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_strobe cyc=%0d got=none exp=%s@%0d", cyc,
                 ev.is_rise ? "rise" : "update", ev.cyc);
      end
      chk("rise_and_update_together", int'(core_ch_rise_o & core_ch_update_o), 0);
      if (core_ch_rise_o) begin
        if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].is_rise) begin
          ev = evq.pop_front();
          chk("rise_capture", int'(core_ch_capture_o), int'(ev.d[3]));
          chk("rise_shift", int'(core_ch_shift_o), int'(ev.d[2]));
          chk("rise_tdi", int'(core_ch_tdi_o), int'(ev.d[1]));
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_rise cyc=%0d got=1 exp=0", cyc);
        end
      end else begin
        chk("data_outside_rise", int'({core_ch_capture_o, core_ch_shift_o, core_ch_tdi_o}), 0);
      end
      if (core_ch_update_o) begin
        if (evq.size() > 0 && evq[0].cyc == cyc && !evq[0].is_rise) begin
          ev = evq.pop_front();
          chk("update_pulse", int'(core_ch_update_o), 1);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_update cyc=%0d got=1 exp=0", cyc);
        end
      end
      chk("glitch_cnt", int'(glitch_cnt_o), m_glitch);
      chk("tck_active", int'(tck_active_o), int'(m_active));
      chk("sel", int'(core_ch_sel_o), int'(m_sel));
      chk("id", int'(core_ch_id_o), int'(m_id));
      chk("tdo", int'(tapc_ch_tdo_o), int'(m_tdo));
    end
  end

  task automatic drive(input logic tck);
    @(negedge clk);
    tapc_tck_i        = tck;
    tapc_ch_sel_i     = 2'($urandom_range(0, 3));
    tapc_ch_id_i      = 2'($urandom_range(0, 3));
    tapc_ch_capture_i = 1'($urandom_range(0, 1));
    tapc_ch_shift_i   = 1'($urandom_range(0, 1));
    tapc_ch_tdi_i     = 1'($urandom_range(0, 1));
    tapc_ch_update_i  = 1'($urandom_range(0, 1));
    core_ch_tdo_i     = 1'($urandom_range(0, 1));
  endtask

  task automatic hold(input logic tck, input int n);
    for (int i = 0; i < n; i++) drive(tck);
  endtask

  initial begin
    // reset with TCK toggling
    repeat (4) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tapc_trst_n_i = 1'b1;
    hold(1'b0, 4);

    // clean TCK, period 16 clk
    repeat (12) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end

    // random half-periods, mixing short glitches with valid edges
    repeat (60) begin
      hold(1'b1, $urandom_range(1, 5));
      hold(1'b0, $urandom_range(1, 5));
    end

    // glitch counter saturation
    repeat (260) begin
      hold(1'b1, 1);
      hold(1'b0, 3);
    end
    hold(1'b0, 4);
    chk("glitch_saturated", int'(glitch_cnt_o), 255);

    // TAP reset in the middle of shifting
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 4);
    tapc_trst_n_i = 1'b0;
    repeat (3) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    chk("trst_active_cleared", int'(tck_active_o), 0);
    chk("trst_glitch_kept", int'(glitch_cnt_o), 255);
    tapc_trst_n_i = 1'b1;
    repeat (4) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end

    // idle timeout, then restart
    hold(1'b0, 40);
    chk("idle_active_low", int'(tck_active_o), 0);
    repeat (3) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    hold(1'b0, 8);

    chk("queue_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
